// File: rtl/adc_pack_pkg.sv
// adc_pack_pkg: shared widths and default sizing for the ADC byte packer and its FIFO.
package adc_pack_pkg;
   localparam int DEPTH   = 8;
   localparam int BYTES   = 3;
   localparam int BOARD_W = 4;
   localparam int BYTE_W  = 8;
   localparam int WORD_W  = BOARD_W + BYTE_W * BYTES;
   localparam int LEVEL_W = $clog2(DEPTH) + 1;
endpackage

// File: rtl/pack_fifo.sv
// pack_fifo: synchronous FIFO with occupancy count; push into full succeeds only alongside a pop.
module pack_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 28
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             din,
   output logic [W-1:0]             dout,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0] mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic wr, rd;
   assign rd    = pop && !empty;
   assign wr    = push && (!full || rd);
   assign empty = level == '0;
   assign full  = level == (AW+1)'(DEPTH);
   assign dout  = mem[rp];
   always_ff @(posedge clk)
      if (wr) mem[wp] <= din;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wp    <= '0;
         rp    <= '0;
         level <= '0;
      end else begin
         if (wr) wp <= wp + AW'(1);
         if (rd) rp <= rp + AW'(1);
         level <= level + (AW+1)'(wr) - (AW+1)'(rd);
      end
endmodule

// File: rtl/adc_pack_fifo.sv
// adc_pack_fifo: packs strobed ADC bytes plus a board tag into words and queues them for a memory writer.
module adc_pack_fifo
   import adc_pack_pkg::BOARD_W, adc_pack_pkg::BYTE_W;
#(
   parameter int DEPTH = adc_pack_pkg::DEPTH,
   parameter int BYTES = adc_pack_pkg::BYTES
) (
   input  logic                              FRC_IN,
   input  logic                              _RES_HARD,
   input  logic                              CLK_BUFER,
   input  logic                              WRITE_BUFER,
   input  logic [BOARD_W-1:0]                COUNT_BOARD,
   input  logic [BYTE_W-1:0]                 DATA_IN,
   input  logic                              MEM_RDY,
   output logic                              MEM_WE,
   output logic [BOARD_W+BYTE_W*BYTES-1:0]   MEM_DATA,
   output logic [$clog2(DEPTH):0]            FIFO_LEVEL,
   output logic                              OVERRUN,
   output logic                              FRAME_ERR
);
   localparam int WW = BOARD_W + BYTE_W * BYTES;
   localparam int IW = BYTES > 1 ? $clog2(BYTES) : 1;
   localparam logic [IW-1:0] LAST = IW'(BYTES - 1);
   logic cb_q, wb_q, cb_edge, wb_edge, push_q, pop, empty, full, misaligned;
   logic [IW-1:0] idx, idx_n;
   logic [BOARD_W-1:0] tag, tag_n;
   logic [BYTES-1:0][BYTE_W-1:0] slots, slots_n;
   logic [WW-1:0] word_q, head;
   assign cb_edge    = CLK_BUFER && !cb_q;
   assign wb_edge    = WRITE_BUFER && !wb_q;
   assign idx_n      = cb_edge ? (idx == LAST ? '0 : idx + IW'(1)) : idx;
   assign tag_n      = (cb_edge && idx == '0) ? COUNT_BOARD : tag;
   // alignment is judged after any coinciding capture has advanced idx
   assign misaligned = wb_edge && idx_n != '0;
   assign pop        = MEM_RDY && !empty;
   assign MEM_WE     = !empty;
   assign MEM_DATA   = empty ? '0 : head;
   always_comb begin
      slots_n = slots;
      if (cb_edge) slots_n[idx] = DATA_IN;
   end
   always_ff @(posedge FRC_IN or negedge _RES_HARD)
      if (!_RES_HARD) begin
         cb_q      <= 1'b0;
         wb_q      <= 1'b0;
         idx       <= '0;
         tag       <= '0;
         slots     <= '0;
         push_q    <= 1'b0;
         word_q    <= '0;
         FRAME_ERR <= 1'b0;
         OVERRUN   <= 1'b0;
      end else begin
         cb_q      <= CLK_BUFER;
         wb_q      <= WRITE_BUFER;
         slots     <= slots_n;
         tag       <= tag_n;
         push_q    <= cb_edge && idx == LAST;
         word_q    <= {tag_n, slots_n};
         idx       <= misaligned ? '0 : idx_n;
         FRAME_ERR <= misaligned;
         if (push_q && full && !pop) OVERRUN <= 1'b1;
      end
   pack_fifo #(.DEPTH(DEPTH), .W(WW)) u_fifo (
      .clk   (FRC_IN),
      .rst_n (_RES_HARD),
      .push  (push_q),
      .pop   (pop),
      .din   (word_q),
      .dout  (head),
      .empty (empty),
      .full  (full),
      .level (FIFO_LEVEL)
   );
endmodule

// File: tb/tb_adc_pack_fifo.sv
// tb_adc_pack_fifo: scenario tasks with inline checks against a word-level queue model of the packer.
module tb_adc_pack_fifo;
   logic clk = 0, rst_n = 0, cb = 0, wb = 0, rdy = 0;
   logic [3:0] board = 0;
   logic [7:0] din = 0;
   logic we, ovr, ferr;
   logic [27:0] data;
   logic [3:0] level;
   int errors = 0, checks = 0;
   logic [27:0] q[$];

   adc_pack_fifo dut (
      .FRC_IN(clk), ._RES_HARD(rst_n), .CLK_BUFER(cb), .WRITE_BUFER(wb),
      .COUNT_BOARD(board), .DATA_IN(din), .MEM_RDY(rdy), .MEM_WE(we),
      .MEM_DATA(data), .FIFO_LEVEL(level), .OVERRUN(ovr), .FRAME_ERR(ferr)
   );

   always #5 clk = ~clk;

   function automatic logic [27:0] mk(input logic [3:0] b, input logic [7:0] b0, b1, b2);
      return {b, b2, b1, b0};
   endfunction

   task automatic strobe(input logic [7:0] d, input logic [3:0] b, input logic w);
      @(negedge clk);
      din = d; board = b; cb = 1; wb = w;
      @(negedge clk);
      cb = 0; wb = 0; din = 8'($urandom); board = 4'($urandom);
   endtask

   task automatic rand_word(output logic [27:0] w);
      logic [7:0] b0, b1, b2;
      logic [3:0] t;
      b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom); t = 4'($urandom);
      strobe(b0, t, 0); strobe(b1, 4'($urandom), 0); strobe(b2, 4'($urandom), 0);
      w = mk(t, b0, b1, b2);
   endtask

   task automatic flush();
      @(negedge clk); rdy = 1;
      repeat (10) @(negedge clk);
      rdy = 0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks += 4;
      if (we !== 0) begin errors++; $display("FAIL reset_we got=%b exp=0", we); end
      if (level !== 0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
      if (ovr !== 0) begin errors++; $display("FAIL reset_ovr got=%b exp=0", ovr); end
      if (ferr !== 0) begin errors++; $display("FAIL reset_ferr got=%b exp=0", ferr); end
      rst_n = 1;
   endtask

   task automatic test_word();
      rdy = 1;
      strobe(8'h11, 4'd5, 0); strobe(8'h22, 4'd6, 0); strobe(8'h33, 4'd7, 0);
      @(negedge clk);
      checks += 3;
      if (we !== 1) begin errors++; $display("FAIL word_we got=%b exp=1", we); end
      if (data !== 28'h5332211) begin errors++; $display("FAIL word_data got=%h exp=5332211", data); end
      @(negedge clk);
      if (we !== 0) begin errors++; $display("FAIL word_we_once got=%b exp=0", we); end
      rdy = 0;
   endtask

   task automatic test_frame_err();
      logic [27:0] w;
      strobe(8'hAA, 4'd1, 0); strobe(8'hBB, 4'd2, 0);
      @(negedge clk); wb = 1;
      @(negedge clk); wb = 0;
      checks += 4;
      if (ferr !== 1) begin errors++; $display("FAIL ferr_pulse got=%b exp=1", ferr); end
      @(negedge clk);
      if (ferr !== 0) begin errors++; $display("FAIL ferr_width got=%b exp=0", ferr); end
      if (level !== 0) begin errors++; $display("FAIL ferr_nopush got=%0d exp=0", level); end
      rand_word(w);
      @(negedge clk);
      if (data !== w || level !== 1) begin
         errors++; $display("FAIL ferr_realign got=%h/%0d exp=%h/1", data, level, w);
      end
      flush();
   endtask

   task automatic test_random();
      logic [7:0] b [3];
      logic [3:0] t;
      int n;
      logic co;
      rdy = 1;
      for (int f = 0; f < 24; f++) begin
         n = $urandom_range(1, 3); co = 1'($urandom);
         t = 4'($urandom);
         for (int k = 0; k < n; k++) begin
            b[k] = 8'($urandom);
            strobe(b[k], k == 0 ? t : 4'($urandom), n == 3 && k == 2 && co);
         end
         checks++;
         if (ferr !== 0) begin errors++; $display("FAIL rnd_ferr_early f=%0d got=%b exp=0", f, ferr); end
         if (n == 3) begin
            @(negedge clk);
            checks++;
            if (we !== 1 || data !== mk(t, b[0], b[1], b[2])) begin
               errors++; $display("FAIL rnd_word f=%0d got=%b/%h exp=1/%h", f, we, data, mk(t, b[0], b[1], b[2]));
            end
         end else begin
            @(negedge clk); wb = 1;
            @(negedge clk); wb = 0;
            checks++;
            if (ferr !== 1 || we !== 0) begin
               errors++; $display("FAIL rnd_frame f=%0d got=%b/%b exp=1/0", f, ferr, we);
            end
         end
         @(negedge clk);
      end
      rdy = 0;
   endtask

   task automatic test_overrun();
      logic [27:0] w;
      q = {};
      for (int i = 0; i < 9; i++) begin
         rand_word(w);
         if (i < 8) q.push_back(w);
      end
      @(negedge clk);
      checks += 2;
      if (level !== 8) begin errors++; $display("FAIL ovr_level got=%0d exp=8", level); end
      if (ovr !== 1) begin errors++; $display("FAIL ovr_flag got=%b exp=1", ovr); end
      rdy = 1;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (we !== 1 || data !== q[i]) begin errors++; $display("FAIL ovr_drain i=%0d got=%h exp=%h", i, data, q[i]); end
         @(negedge clk);
      end
      rdy = 0;
      checks += 2;
      if (we !== 0 || level !== 0) begin errors++; $display("FAIL ovr_empty got=%b/%0d exp=0/0", we, level); end
      if (ovr !== 1) begin errors++; $display("FAIL ovr_sticky got=%b exp=1", ovr); end
   endtask

   task automatic test_reset_mid();
      logic [27:0] w;
      repeat (3) rand_word(w);
      strobe(8'h5A, 4'd3, 0);
      @(negedge clk);
      checks += 3;
      if (level !== 3) begin errors++; $display("FAIL rst_pre_level got=%0d exp=3", level); end
      #2 rst_n = 0;
      #1;
      if (we !== 0 || level !== 0 || data !== 0) begin
         errors++; $display("FAIL rst_async got=%b/%0d/%h exp=0/0/0", we, level, data);
      end
      if (ovr !== 0 || ferr !== 0) begin errors++; $display("FAIL rst_flags got=%b/%b exp=0/0", ovr, ferr); end
      @(negedge clk); rst_n = 1;
      rand_word(w);
      @(negedge clk);
      checks++;
      if (level !== 1 || data !== w) begin errors++; $display("FAIL rst_clean got=%0d/%h exp=1/%h", level, data, w); end
      flush();
   endtask

   task automatic test_full_pushpop();
      logic [27:0] w;
      q = {};
      for (int i = 0; i < 8; i++) begin rand_word(w); q.push_back(w); end
      rand_word(w);
      q.push_back(w);
      rdy = 1;
      @(negedge clk);
      rdy = 0;
      void'(q.pop_front());
      checks += 2;
      if (level !== 8) begin errors++; $display("FAIL full_pp_level got=%0d exp=8", level); end
      if (ovr !== 0) begin errors++; $display("FAIL full_pp_ovr got=%b exp=0", ovr); end
      rdy = 1;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (data !== q[i]) begin errors++; $display("FAIL full_pp_drain i=%0d got=%h exp=%h", i, data, q[i]); end
         @(negedge clk);
      end
      rdy = 0;
   endtask

   task automatic test_hold();
      logic [7:0] d0, d1, d2;
      logic [3:0] t;
      d0 = 8'($urandom); t = 4'($urandom);
      @(negedge clk); cb = 1; din = d0; board = t;
      repeat (3) begin @(negedge clk); din = 8'($urandom); board = 4'($urandom); end
      @(negedge clk); cb = 0;
      d1 = 8'($urandom); d2 = 8'($urandom);
      strobe(d1, 4'($urandom), 0); strobe(d2, 4'($urandom), 0);
      @(negedge clk);
      checks++;
      if (level !== 1 || data !== mk(t, d0, d1, d2)) begin
         errors++; $display("FAIL hold got=%0d/%h exp=1/%h", level, data, mk(t, d0, d1, d2));
      end
   endtask

   initial begin
      test_reset();
      test_word();
      test_frame_err();
      test_random();
      test_overrun();
      test_reset_mid();
      test_full_pushpop();
      test_hold();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/adc_pack_fifo.md
ADC_PACK_FIFO -- requirements
Module: adc_pack_fifo

Interface
REQ-001 Parameter DEPTH, default 8: FIFO depth in words, power of two, 2..16.
REQ-002 Parameter BYTES, default 3: bytes packed per word, matching the three CLK_BUFER strobes per F-cycle.
REQ-003 FRC_IN  in  1  single clock; all logic on rising edge.
REQ-004 _RES_HARD  in  1  asynchronous, active-low reset.
REQ-005 CLK_BUFER  in  1  byte-capture strobe, level, synchronous to FRC_IN; its rising edge captures DATA_IN.
REQ-006 WRITE_BUFER  in  1  frame-end marker, level; its rising edge checks packing alignment.
REQ-007 COUNT_BOARD  in  4  board index, tagged onto each word.
REQ-008 DATA_IN  in  8  ADC byte, valid in the cycle the CLK_BUFER rising edge is detected.
REQ-009 MEM_RDY  in  1  downstream memory writer accepts a word.
REQ-010 MEM_WE  out  1  FIFO head is valid.
REQ-011 MEM_DATA  out  4+8*BYTES  {board, byte[BYTES-1] .. byte[0]}; 28 bits at default.
REQ-012 FIFO_LEVEL  out  log2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-013 OVERRUN  out  1  sticky flag: a completed word was dropped.
REQ-014 FRAME_ERR  out  1  one-cycle pulse: a partial word was discarded.

Function
REQ-015 Edge detection shall use one register per strobe; an edge is detected when the input is 1 now and the register holds 0.
REQ-016 A CLK_BUFER edge shall store DATA_IN into slot idx, then increment idx; idx runs 0..BYTES-1.
REQ-017 On the edge with idx=0, COUNT_BOARD shall be latched as the word tag.
REQ-018 On the edge with idx=BYTES-1, idx shall wrap to 0 and the assembled word shall be pushed into the FIFO on the next clock edge; one-cycle push latency.
REQ-019 A WRITE_BUFER edge with idx not 0 shall clear idx to 0, discard the partial bytes, and pulse FRAME_ERR for exactly one cycle.
REQ-020 A WRITE_BUFER edge with idx=0 shall have no effect.
REQ-021 If the CLK_BUFER and WRITE_BUFER edges coincide, the byte shall be captured first and the alignment check shall then apply to the resulting idx.
REQ-022 MEM_WE shall equal "FIFO not empty"; MEM_DATA shall always present the FIFO head.
REQ-023 A word transfers in any cycle with MEM_WE=1 and MEM_RDY=1; the pop takes effect on that clock edge.
REQ-024 While MEM_WE=1 and MEM_RDY=0, MEM_DATA shall stay stable.
REQ-025 A word written into an empty FIFO shall raise MEM_WE on the edge that completes the push; no read-side bypass.
REQ-026 A push into a full FIFO with no pop in the same cycle shall drop the word and set OVERRUN; FIFO contents and level shall be unchanged.
REQ-027 A push and a pop in the same cycle shall both succeed at any level, including full; the level is unchanged.
REQ-028 A pop when the FIFO is empty is impossible, since MEM_WE=0.
REQ-029 FIFO_LEVEL shall update on the same edge as the push or pop; read and write pointers wrap modulo DEPTH.
REQ-030 OVERRUN shall be cleared only by reset.

Reset
REQ-031 _RES_HARD=0 shall asynchronously clear idx, the tag, byte slots, pointers, edge registers, FIFO_LEVEL, OVERRUN, FRAME_ERR and MEM_WE to 0; FIFO storage need not be cleared.
REQ-032 Reset asserted mid-word or mid-transfer shall abandon all data; a word not yet accepted is lost.
REQ-033 After reset release, the first CLK_BUFER edge is the first edge seen with the edge register at 0; a strobe already high at release counts as an edge.

Structure
REQ-034 Package adc_pack_pkg shall hold DEPTH, BYTES, BOARD_W=4, BYTE_W=8 and the derived WORD_W and LEVEL_W constants.
REQ-035 The FIFO shall be the sub-module pack_fifo (push, pop, din, dout, empty, full, level); packing and edge logic stay in adc_pack_fifo.

Verification
REQ-036 Three CLK_BUFER edges with DATA_IN 0x11, 0x22, 0x33 and COUNT_BOARD=5 at the first, MEM_RDY=1 -> one MEM_WE cycle, MEM_DATA=0x5332211.
REQ-037 Two CLK_BUFER edges, then a WRITE_BUFER edge -> FRAME_ERR high for exactly one cycle, no push; the next three bytes form a correct word.
REQ-038 MEM_RDY=0 and nine words pushed -> FIFO_LEVEL=8, OVERRUN=1, and the ninth word absent when draining; the drain yields words 1..8 in order.
REQ-039 FIFO full, MEM_RDY=1, new word completing in the same cycle -> FIFO_LEVEL stays 8, OVERRUN stays 0.
REQ-040 _RES_HARD pulsed low after one byte and with 3 words queued -> all outputs 0 immediately (asynchronous); the next three bytes give a clean word.
REQ-041 CLK_BUFER held high for 4 cycles -> exactly one byte captured.
